// File: rtl/uart_if.sv
// rtl/uart_if.sv - UART serial lines and parallel tx/rx handshake bundle
interface uart_if #(parameter int DATA_WIDTH = 8);
   logic                  rx;
   logic                  tx;
   logic [DATA_WIDTH-1:0] txd;
   logic                  txv;
   logic                  rdy;
   logic                  tx_active;
   logic [DATA_WIDTH-1:0] rxd;
   logic                  rxv;

   modport master (output rx, txd, txv, input tx, rdy, tx_active, rxd, rxv);
   modport slave  (input rx, txd, txv, output tx, rdy, tx_active, rxd, rxv);
endinterface

// File: rtl/uart.sv
// rtl/uart.sv - UART with independent TX/RX and majority-vote sampling
// Define UART_RX_ERR_EN to drop received frames with parity or stop-bit errors.
module uart #(
   parameter int DATA_WIDTH      = 8,
   parameter int STOP_BITS       = 1,
   parameter int PARITY          = 1,
   parameter int EVEN            = 0,
   parameter int PRESCALER       = 25,
   parameter int LATCH_TOLERANCE = 7
) (
   input logic   clk,
   input logic   rst,
   uart_if.slave bus
);
   localparam int CW = $clog2(PRESCALER);
   localparam int VW = $clog2(2 * LATCH_TOLERANCE + 2);
   localparam logic [CW-1:0] BIT_END = CW'(PRESCALER - 1);
   localparam logic [CW-1:0] WIN_LO  = CW'(PRESCALER / 2 - LATCH_TOLERANCE);
   localparam logic [CW-1:0] WIN_HI  = CW'(PRESCALER / 2 + LATCH_TOLERANCE);
   localparam logic [3:0] DATA_LAST  = 4'(DATA_WIDTH - 1);
   localparam logic [3:0] STOP_LAST  = 4'(STOP_BITS - 1);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

   state_t                tx_state, tx_next;
   logic [CW-1:0]         tx_cnt;
   logic [3:0]            tx_bit;
   logic [DATA_WIDTH-1:0] tx_shift;
   logic                  tx_par;
   logic                  tx_bit_end;
   logic                  accept;

   assign tx_bit_end = (tx_cnt == BIT_END);
   assign accept     = (tx_state == S_IDLE) && bus.txv;

   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state <= S_IDLE;
         tx_cnt   <= '0;
         tx_bit   <= '0;
         tx_shift <= '0;
         tx_par   <= 1'b0;
      end else begin
         tx_state <= tx_next;
         if (tx_state == S_IDLE || tx_bit_end) tx_cnt <= '0;
         else                                  tx_cnt <= tx_cnt + CW'(1);
         if (tx_state != tx_next) tx_bit <= '0;
         else if (tx_bit_end)     tx_bit <= tx_bit + 4'd1;
         if (accept) begin
            tx_shift <= bus.txd;
            tx_par   <= (EVEN != 0) ? ^bus.txd : ~^bus.txd;
         end else if (tx_state == S_DATA && tx_bit_end) begin
            tx_shift <= {1'b0, tx_shift[DATA_WIDTH-1:1]};
         end
      end
   end

   always_comb begin
      tx_next = tx_state;
      unique case (tx_state)
         S_IDLE:   if (bus.txv) tx_next = S_START;
         S_START:  if (tx_bit_end) tx_next = S_DATA;
         S_DATA:   if (tx_bit_end && tx_bit == DATA_LAST) tx_next = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (tx_bit_end) tx_next = S_STOP;
         S_STOP:   if (tx_bit_end && tx_bit == STOP_LAST) tx_next = S_IDLE;
         default:  tx_next = S_IDLE;
      endcase
   end

   always_comb begin
      bus.tx        = 1'b1;
      bus.rdy       = 1'b0;
      bus.tx_active = 1'b1;
      case (tx_state)
         S_IDLE:   begin bus.rdy = 1'b1; bus.tx_active = 1'b0; end
         S_START:  bus.tx = 1'b0;
         S_DATA:   bus.tx = tx_shift[0];
         S_PARITY: bus.tx = tx_par;
         default:  bus.tx = 1'b1;
      endcase
   end

   // rx_s3 is the previous synchronized sample, used only for start-edge detection
   logic                  rx_s1, rx_s2, rx_s3;
   state_t                rx_state, rx_next;
   logic [CW-1:0]         rx_cnt;
   logic [3:0]            rx_bit;
   logic [VW-1:0]         rx_ones;
   logic [DATA_WIDTH-1:0] rx_shift;
   logic                  rx_bit_end, in_win, win_end, vote, frame_ok, rx_take;

   assign rx_bit_end = (rx_cnt == BIT_END);
   assign in_win     = (rx_cnt >= WIN_LO) && (rx_cnt <= WIN_HI);
   assign win_end    = (rx_cnt == WIN_HI);
   assign vote       = (rx_ones + VW'(rx_s2)) > VW'(LATCH_TOLERANCE);

`ifdef UART_RX_ERR_EN
   logic rx_par;
   logic par_ok;
   assign par_ok   = (PARITY == 0) || ((^rx_shift ^ rx_par) == (EVEN == 0));
   assign frame_ok = par_ok && vote;
`else
   assign frame_ok = 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_s1    <= 1'b1;
         rx_s2    <= 1'b1;
         rx_s3    <= 1'b1;
         rx_state <= S_IDLE;
         rx_cnt   <= '0;
         rx_bit   <= '0;
         rx_ones  <= '0;
         rx_shift <= '0;
         bus.rxd  <= '0;
         bus.rxv  <= 1'b0;
`ifdef UART_RX_ERR_EN
         rx_par   <= 1'b0;
`endif
      end else begin
         rx_s1    <= bus.rx;
         rx_s2    <= rx_s1;
         rx_s3    <= rx_s2;
         rx_state <= rx_next;
         // the edge cycle itself is cycle 0 of the start bit, so START begins at 1
         if (rx_state == S_IDLE) rx_cnt <= CW'(1);
         else if (rx_bit_end)    rx_cnt <= '0;
         else                    rx_cnt <= rx_cnt + CW'(1);
         if (rx_state != rx_next) rx_bit <= '0;
         else if (rx_bit_end)     rx_bit <= rx_bit + 4'd1;
         if (rx_state == S_IDLE || rx_bit_end) rx_ones <= '0;
         else if (in_win)                      rx_ones <= rx_ones + VW'(rx_s2);
         if (rx_state == S_DATA && win_end) rx_shift <= {vote, rx_shift[DATA_WIDTH-1:1]};
`ifdef UART_RX_ERR_EN
         if (rx_state == S_PARITY && win_end) rx_par <= vote;
`endif
         bus.rxv <= rx_take;
         if (rx_take) bus.rxd <= rx_shift;
      end
   end

   always_comb begin
      rx_next = rx_state;
      unique case (rx_state)
         S_IDLE:   if (rx_s3 && !rx_s2) rx_next = S_START;
         S_START:  if (win_end && vote) rx_next = S_IDLE;
                   else if (rx_bit_end) rx_next = S_DATA;
         S_DATA:   if (rx_bit_end && rx_bit == DATA_LAST) rx_next = (PARITY != 0) ? S_PARITY : S_STOP;
         S_PARITY: if (rx_bit_end) rx_next = S_STOP;
         S_STOP:   if (win_end) rx_next = S_IDLE;
         default:  rx_next = S_IDLE;
      endcase
   end

   always_comb begin
      rx_take = 1'b0;
      if (rx_state == S_STOP && win_end) rx_take = frame_ok;
   end
endmodule

// File: tb/tb_uart.sv
// tb/tb_uart.sv - scoreboard bench for uart in loopback plus an even-parity two-stop instance
module tb_uart;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uart_if #(.DATA_WIDTH(8)) u_if ();
   uart_if #(.DATA_WIDTH(8)) e_if ();
   logic loop_en = 1'b1;
   logic rx_drv  = 1'b1;
   assign u_if.rx = loop_en ? u_if.tx : rx_drv;
   assign e_if.rx = e_if.tx;

   uart u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));
   uart #(.EVEN(1), .STOP_BITS(2)) e_dut (.clk(clk), .rst(rst), .bus(e_if.slave));

   int total = 0;
   int bad = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_v;
   int rxv_cnt = 0;
   int e_rxv_cnt = 0;
   logic [7:0] e_rxd_last = 8'h00;
   logic prev_rxv = 1'b0;

   always @(negedge clk) begin
      if (u_if.rxv === 1'b1) begin
         rxv_cnt++;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL rx_unexpected rxd=%h expected=none", u_if.rxd);
         end else begin
            exp_v = exp_q.pop_front();
            if (u_if.rxd !== exp_v) begin
               bad++;
               $display("FAIL rx_data rxd=%h expected=%h", u_if.rxd, exp_v);
            end
         end
         total++;
         if (prev_rxv === 1'b1) begin
            bad++;
            $display("FAIL rxv_pulse_width rxv held=1 expected=single cycle");
         end
      end
      prev_rxv = u_if.rxv;
      if (e_if.rxv === 1'b1) begin
         e_rxv_cnt++;
         e_rxd_last = e_if.rxd;
      end
   end

   task automatic wait_rdy(input int lim);
      int n = 0;
      while (u_if.rdy !== 1'b1 && n < lim) begin
         @(negedge clk);
         n++;
      end
      if (u_if.rdy !== 1'b1) begin
         total++; bad++;
         $display("FAIL rdy_timeout rdy=%b expected=1", u_if.rdy);
      end
   endtask

   task automatic send_frame(input logic [7:0] d, input bit hold2, input bit poke);
      logic [10:0] got = '0;
      logic [10:0] want;
      want = {1'b1, ~^d, d, 1'b0};
      wait_rdy(400);
      exp_q.push_back(d);
      u_if.txd = d;
      u_if.txv = 1'b1;
      @(negedge clk);
      for (int i = 0; i <= 275; i++) begin
         if (i % 25 == 12) got[i/25] = u_if.tx;
         if (i == 274) begin
            total++;
            if (u_if.rdy !== 1'b0 || u_if.tx_active !== 1'b1) begin
               bad++;
               $display("FAIL last_stop_cycle rdy=%b tx_active=%b expected rdy=0 tx_active=1", u_if.rdy, u_if.tx_active);
            end
         end
         if (i == 275) begin
            total++;
            if (u_if.rdy !== 1'b1 || u_if.tx_active !== 1'b0) begin
               bad++;
               $display("FAIL rdy_return rdy=%b tx_active=%b expected rdy=1 tx_active=0", u_if.rdy, u_if.tx_active);
            end
         end
         if (i == (hold2 ? 1 : 0)) u_if.txv = 1'b0;
         if (poke && i == 100) u_if.txv = 1'b1;
         if (poke && i == 101) u_if.txv = 1'b0;
         @(negedge clk);
      end
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL frame_bits got=%b expected=%b", got, want);
      end
   endtask

   task automatic drive_rx(input logic [7:0] d, input logic par);
      logic [10:0] bits;
      bits = {1'b1, par, d, 1'b0};
      for (int b = 0; b < 11; b++) begin
         rx_drv = bits[b];
         repeat (25) @(negedge clk);
      end
      repeat (10) @(negedge clk);
   endtask

   task automatic check_rxv_count(input string name, input int want);
      total++;
      if (rxv_cnt !== want) begin
         bad++;
         $display("FAIL %s rxv_count=%0d expected=%0d", name, rxv_cnt, want);
      end
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      total++;
      if (u_if.tx !== 1'b1 || u_if.rdy !== 1'b1 || u_if.tx_active !== 1'b0) begin
         bad++;
         $display("FAIL reset_tx tx=%b rdy=%b tx_active=%b expected 1 1 0", u_if.tx, u_if.rdy, u_if.tx_active);
      end
      total++;
      if (u_if.rxv !== 1'b0 || u_if.rxd !== 8'h00) begin
         bad++;
         $display("FAIL reset_rx rxv=%b rxd=%h expected 0 00", u_if.rxv, u_if.rxd);
      end
      total++;
      if (e_if.tx !== 1'b1 || e_if.rdy !== 1'b1) begin
         bad++;
         $display("FAIL reset_even tx=%b rdy=%b expected 1 1", e_if.tx, e_if.rdy);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single_ff;
      int c0 = rxv_cnt;
      send_frame(8'hFF, 1'b1, 1'b0);
      check_rxv_count("single_ff", c0 + 1);
   endtask

   task automatic test_patterns;
      int c0 = rxv_cnt;
      send_frame(8'h00, 1'b0, 1'b0);
      check_rxv_count("pattern_00", c0 + 1);
      send_frame(8'hA5, 1'b0, 1'b0);
      check_rxv_count("pattern_a5", c0 + 2);
   endtask

   task automatic test_busy_ignored;
      int c0 = rxv_cnt;
      bit extra = 1'b0;
      send_frame(8'h5A, 1'b0, 1'b1);
      repeat (60) begin
         if (u_if.tx_active !== 1'b0 || u_if.tx !== 1'b1) extra = 1'b1;
         @(negedge clk);
      end
      total++;
      if (extra) begin
         bad++;
         $display("FAIL busy_queued extra_frame=1 expected=0");
      end
      check_rxv_count("busy_rx", c0 + 1);
   endtask

   task automatic test_back_to_back;
      int c0 = rxv_cnt;
      int n = 0;
      wait_rdy(400);
      exp_q.push_back(8'h3C);
      exp_q.push_back(8'hC3);
      u_if.txd = 8'h3C;
      u_if.txv = 1'b1;
      @(negedge clk);
      u_if.txd = 8'hC3;
      while (u_if.rdy !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      u_if.txv = 1'b0;
      total++;
      if (u_if.tx_active !== 1'b1 || u_if.tx !== 1'b0) begin
         bad++;
         $display("FAIL b2b_second_start tx_active=%b tx=%b expected 1 0", u_if.tx_active, u_if.tx);
      end
      wait_rdy(400);
      repeat (20) @(negedge clk);
      check_rxv_count("b2b_rx", c0 + 2);
   endtask

   task automatic test_glitch_and_parity;
      int c0 = rxv_cnt;
      logic [7:0] saved;
      loop_en = 1'b0;
      rx_drv = 1'b1;
      repeat (5) @(negedge clk);
      rx_drv = 1'b0;
      repeat (5) @(negedge clk);
      rx_drv = 1'b1;
      repeat (300) @(negedge clk);
      check_rxv_count("glitch", c0);
      exp_q.push_back(8'h4B);
      drive_rx(8'h4B, 1'b1);
      check_rxv_count("ext_good", c0 + 1);
      saved = u_if.rxd;
`ifdef UART_RX_ERR_EN
      drive_rx(8'h96, 1'b0);
      check_rxv_count("bad_parity_drop", c0 + 1);
      total++;
      if (u_if.rxd !== saved) begin
         bad++;
         $display("FAIL bad_parity_rxd rxd=%h expected=%h", u_if.rxd, saved);
      end
`else
      exp_q.push_back(8'h96);
      drive_rx(8'h96, 1'b0);
      check_rxv_count("bad_parity_pass", c0 + 2);
`endif
      loop_en = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_even_two_stop;
      logic [11:0] got = '0;
      logic [11:0] want;
      int len = 0;
      int c0 = e_rxv_cnt;
      int n = 0;
      want = {2'b11, 1'b0, 8'h03, 1'b0};
      while (e_if.rdy !== 1'b1 && n < 400) begin
         @(negedge clk);
         n++;
      end
      e_if.txd = 8'h03;
      e_if.txv = 1'b1;
      @(negedge clk);
      e_if.txv = 1'b0;
      for (int i = 0; i < 330; i++) begin
         if (i < 300 && i % 25 == 12) got[i/25] = e_if.tx;
         if (e_if.tx_active === 1'b1) len++;
         @(negedge clk);
      end
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL even_frame_bits got=%b expected=%b", got, want);
      end
      total++;
      if (len !== 300) begin
         bad++;
         $display("FAIL even_frame_len len=%0d expected=300", len);
      end
      total++;
      if (e_rxv_cnt !== c0 + 1 || e_rxd_last !== 8'h03) begin
         bad++;
         $display("FAIL even_rx count=%0d rxd=%h expected count=%0d rxd=03", e_rxv_cnt, e_rxd_last, c0 + 1);
      end
   endtask

   task automatic test_reset_mid;
      int c0 = rxv_cnt;
      wait_rdy(400);
      u_if.txd = 8'h77;
      u_if.txv = 1'b1;
      @(negedge clk);
      u_if.txv = 1'b0;
      repeat (110) @(negedge clk);
      rst = 1'b1;
      u_if.txv = 1'b1;
      @(negedge clk);
      total++;
      if (u_if.tx !== 1'b1 || u_if.rdy !== 1'b1 || u_if.tx_active !== 1'b0 || u_if.rxv !== 1'b0) begin
         bad++;
         $display("FAIL mid_reset tx=%b rdy=%b tx_active=%b rxv=%b expected 1 1 0 0",
                  u_if.tx, u_if.rdy, u_if.tx_active, u_if.rxv);
      end
      rst = 1'b0;
      u_if.txv = 1'b0;
      @(negedge clk);
      total++;
      if (u_if.tx_active !== 1'b0) begin
         bad++;
         $display("FAIL txv_during_reset tx_active=%b expected=0", u_if.tx_active);
      end
      repeat (300) @(negedge clk);
      check_rxv_count("mid_reset_rx", c0);
   endtask

   initial begin
      u_if.txd = 8'h00;
      u_if.txv = 1'b0;
      e_if.txd = 8'h00;
      e_if.txv = 1'b0;
      test_reset;
      test_single_ff;
      test_patterns;
      test_busy_ignored;
      test_back_to_back;
      test_glitch_and_parity;
      test_even_two_stop;
      test_reset_mid;
      total++;
      if (exp_q.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_left pending=%0d expected=0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
